// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: debounced start/stop and clear keys drive an IDLE/RUN/PAUSE FSM
// that gates a prescaler producing the BCD counter's TICK and CLR pulses.

module stopwatch_key_db #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int DB_W            = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic key_raw,
    output logic press
);
    logic            sync1, sync2, db, db_prev;
    logic [DB_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            db      <= 1'b1;
            db_prev <= 1'b1;
            cnt     <= '0;
            press   <= 1'b0;
        end else begin
            sync1   <= key_raw;
            sync2   <= sync1;
            db_prev <= db;
            press   <= db_prev & ~db;
            // Flip only once the synced level has disagreed for a full window.
            if (sync2 == db) begin
                cnt <= '0;
            end else if (cnt == DB_W'(DEBOUNCE_CYCLES)) begin
                db  <= sync2;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

module stopwatch_ctrl #(
    parameter int CLK_HZ          = 50000000,
    parameter int TICK_HZ         = 1,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 26,
    parameter int DB_W            = 20
) (
    input  logic       CLOCK_50,
    input  logic       RESET,
    input  logic       KEY_SS,
    input  logic       KEY_CLR,
    output logic       TICK,
    output logic       CLR,
    output logic       RUNNING,
    output logic [1:0] STATE
);
    localparam int NUM_KEYS = 2;
    localparam int DIV      = CLK_HZ / TICK_HZ;
    localparam logic [CNT_W-1:0] DIV_M1 = CNT_W'(DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10
    } state_t;

    state_t                state;
    logic [CNT_W-1:0]      presc;
    logic [NUM_KEYS-1:0]   keys, press;

    assign keys  = {KEY_CLR, KEY_SS};
    assign STATE = state;

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        stopwatch_key_db #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .DB_W            (DB_W)
        ) u_key (
            .clk     (CLOCK_50),
            .rst     (RESET),
            .key_raw (keys[k]),
            .press   (press[k])
        );
    end

    // press[1] is clear and always beats a simultaneous start/stop.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            state   <= S_IDLE;
            presc   <= '0;
            TICK    <= 1'b0;
            CLR     <= 1'b0;
            RUNNING <= 1'b0;
        end else begin
            TICK <= 1'b0;
            CLR  <= 1'b0;
            case (state)
                S_IDLE: begin
                    presc <= '0;
                    if (press[1]) begin
                        CLR <= 1'b1;
                    end else if (press[0]) begin
                        state   <= S_RUN;
                        RUNNING <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (presc == DIV_M1) begin
                        presc <= '0;
                        TICK  <= 1'b1;
                    end else begin
                        presc <= presc + 1'b1;
                    end
                    if (press[1]) begin
                        state   <= S_IDLE;
                        CLR     <= 1'b1;
                        RUNNING <= 1'b0;
                    end else if (press[0]) begin
                        state   <= S_PAUSE;
                        RUNNING <= 1'b0;
                    end
                end
                S_PAUSE: begin
                    if (press[1]) begin
                        state <= S_IDLE;
                        CLR   <= 1'b1;
                    end else if (press[0]) begin
                        state   <= S_RUN;
                        RUNNING <= 1'b1;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    presc   <= '0;
                    RUNNING <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: a cycle-level behavioural model checked every cycle,
// plus directed latency/period checks with hand-computed offsets.

module tb_stopwatch_ctrl;
    localparam int DIV = 10;
    localparam int DB  = 4;
    localparam int HL  = DB + 3;

    logic       CLOCK_50 = 1'b0;
    logic       RESET    = 1'b1;
    logic       KEY_SS   = 1'b1;
    logic       KEY_CLR  = 1'b1;
    logic       TICK, CLR, RUNNING;
    logic [1:0] STATE;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    bit cmp_en = 1'b0;

    stopwatch_ctrl #(
        .CLK_HZ          (10),
        .TICK_HZ         (1),
        .DEBOUNCE_CYCLES (DB),
        .CNT_W           (4),
        .DB_W            (3)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .RESET    (RESET),
        .KEY_SS   (KEY_SS),
        .KEY_CLR  (KEY_CLR),
        .TICK     (TICK),
        .CLR      (CLR),
        .RUNNING  (RUNNING),
        .STATE    (STATE)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    initial forever begin
        @(posedge CLOCK_50);
        cyc++;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: key level accepted once the last DB+1 synchronised samples all disagree;
    // prescaler phase is the number of RUN cycles since leaving IDLE, modulo DIV.
    int m_state, m_run_edges;
    bit m_tick, m_clr;
    bit m_db[2], m_flipd[2], m_press[2];
    bit hist[2][HL];

    task automatic model_reset();
        m_state = 0; m_run_edges = 0; m_tick = 0; m_clr = 0;
        for (int k = 0; k < 2; k++) begin
            m_db[k] = 1; m_flipd[k] = 0; m_press[k] = 0;
            for (int i = 0; i < HL; i++) hist[k][i] = 1;
        end
    endtask

    task automatic model_step();
        bit raw[2];
        bit flip[2];
        int nstate;
        bit nclr, ntick;
        raw[0] = KEY_SS;
        raw[1] = KEY_CLR;
        for (int k = 0; k < 2; k++) begin
            for (int i = HL - 1; i > 0; i--) hist[k][i] = hist[k][i-1];
            hist[k][0] = raw[k];
            flip[k] = 1;
            for (int i = 2; i <= DB + 2; i++) if (hist[k][i] == m_db[k]) flip[k] = 0;
        end
        nstate = m_state; nclr = 0; ntick = 0;
        if (m_state == 1) begin
            m_run_edges++;
            ntick = (m_run_edges % DIV) == 0;
        end else if (m_state == 0) begin
            m_run_edges = 0;
        end
        if (m_press[1]) begin
            nclr = 1; nstate = 0;
        end else if (m_press[0]) begin
            nstate = (m_state == 1) ? 2 : 1;
        end
        for (int k = 0; k < 2; k++) begin
            m_press[k] = m_flipd[k];
            m_flipd[k] = flip[k] && m_db[k];
            if (flip[k]) m_db[k] = ~m_db[k];
        end
        m_state = nstate; m_tick = ntick; m_clr = nclr;
    endtask

    initial forever begin
        @(posedge CLOCK_50 or posedge RESET);
        if (RESET) model_reset();
        else model_step();
    end

    initial forever begin
        @(negedge CLOCK_50);
        if (cmp_en) begin
            chk("tick",    TICK,    m_tick);
            chk("clr",     CLR,     m_clr);
            chk("state",   STATE,   m_state);
            chk("running", RUNNING, m_state == 1);
        end
    end

    // which: 0 = STATE==val, 1 = TICK, 2 = CLR. t = edge index, -1 on timeout.
    task automatic wait_sig(input int which, input int val, input int budget, output int t);
        t = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge CLOCK_50);
            if ((which == 0 && STATE == val) || (which == 1 && TICK) || (which == 2 && CLR)) begin
                t = cyc;
                break;
            end
        end
    endtask

    task automatic watch(input int cycles, output int nt, output int nc, output int nchg);
        logic [1:0] prev;
        prev = STATE; nt = 0; nc = 0; nchg = 0;
        repeat (cycles) begin
            @(negedge CLOCK_50);
            nt += int'(TICK);
            nc += int'(CLR);
            if (STATE != prev) nchg++;
            prev = STATE;
        end
    endtask

    initial begin
        int t, n, t0, nt, nc, ng;
        bit bp[20] = '{0,1,0,0,1,1,0,1,0,0,1,0,1,1,0,0,1,0,1,0};

        repeat (3) @(negedge CLOCK_50);
        chk("rst_state",   STATE,   0);
        chk("rst_tick",    TICK,    0);
        chk("rst_clr",     CLR,     0);
        chk("rst_running", RUNNING, 0);
        RESET = 0;
        cmp_en = 1;
        repeat (5) @(negedge CLOCK_50);

        // clean start press: RUN at N+8, ticks every 10 from N+18
        n = cyc + 1; KEY_SS = 0;
        wait_sig(0, 1, 20, t); chk("ss_run_lat", t, n + 8);
        chk("model_run", m_state, 1);
        KEY_SS = 1;
        wait_sig(1, 0, 20, t); chk("tick1", t, n + 18);
        chk("model_tick", m_tick, 1);
        wait_sig(1, 0, 20, t); chk("tick2", t, n + 28);
        wait_sig(1, 0, 20, t); chk("tick3", t, n + 38);

        // async reset landing inside a TICK cycle
        wait_sig(1, 0, 20, t);
        #1 RESET = 1;
        #1;
        chk("arst_tick",    TICK,    0);
        chk("arst_state",   STATE,   0);
        chk("arst_clr",     CLR,     0);
        chk("arst_running", RUNNING, 0);
        @(negedge CLOCK_50);
        @(negedge CLOCK_50);
        RESET = 0;
        watch(35, nt, nc, ng);
        chk("post_rst_ticks", nt, 0);
        chk("post_rst_chg",   ng, 0);

        // short glitch, then bouncing press
        KEY_SS = 0;
        repeat (3) @(negedge CLOCK_50);
        KEY_SS = 1;
        watch(20, nt, nc, ng);
        chk("glitch_chg",   ng,    0);
        chk("glitch_state", STATE, 0);
        for (int i = 0; i < 20; i++) begin
            KEY_SS = bp[i];
            @(negedge CLOCK_50);
        end
        chk("bounce_early", STATE, 0);
        KEY_SS = 0;
        watch(30, nt, nc, ng);
        chk("bounce_events", ng,    1);
        chk("bounce_state",  STATE, 1);
        KEY_SS = 1;
        repeat (12) @(negedge CLOCK_50);

        // pause 15 cycles after a tick, resume: next tick 5 cycles later
        wait_sig(1, 0, 20, t0);
        while (cyc < t0 + 6) @(negedge CLOCK_50);
        KEY_SS = 0;
        wait_sig(0, 2, 30, t); chk("pause_lat", t, t0 + 15);
        chk("model_pause", m_state, 2);
        KEY_SS = 1;
        watch(40, nt, nc, ng);
        chk("pause_ticks", nt,    0);
        chk("pause_state", STATE, 2);
        n = cyc + 1; KEY_SS = 0;
        wait_sig(0, 1, 20, t); chk("resume_lat", t, n + 8);
        KEY_SS = 1;
        wait_sig(1, 0, 20, t); chk("resume_tick", t, n + 13);
        repeat (10) @(negedge CLOCK_50);

        // simultaneous SS and CLR in RUN: clear wins
        n = cyc + 1; KEY_SS = 0; KEY_CLR = 0;
        wait_sig(2, 0, 20, t); chk("both_clr_lat", t, n + 8);
        chk("both_state", STATE, 0);
        chk("model_clr",  m_clr, 1);
        @(negedge CLOCK_50);
        chk("both_clr_width", CLR, 0);
        KEY_SS = 1; KEY_CLR = 1;
        repeat (12) @(negedge CLOCK_50);

        // clear in IDLE, key held down for 100 cycles
        n = cyc + 1; KEY_CLR = 0;
        wait_sig(2, 0, 20, t); chk("idle_clr_lat", t, n + 8);
        chk("idle_clr_state", STATE, 0);
        watch(100, nt, nc, ng);
        chk("held_clr_extra", nc, 0);
        chk("held_state_chg", ng, 0);
        KEY_CLR = 1;
        repeat (10) @(negedge CLOCK_50);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
